// File: rtl/uart_tx_ctrl_pkg.sv
// Shared encodings for the UART transmit frame sequencer.
package uart_tx_ctrl_pkg;

   // Frame sequencer states, binary encoded.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Parity type selector values.
   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

   // Line levels for the framing bits.
   localparam logic IDLE_BIT  = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Parity of the accepted byte, captured on accept and held for the whole frame.
module uart_tx_ctrl_parity_calc
   import uart_tx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par_bit
);

   logic par_d;
   logic par_q;

   // Compute the new parity only on accept; otherwise hold the frame's value.
   always_comb begin
      par_d = par_q;
      if (load) begin
         par_d = (^data) ^ (par_typ == ODD);
      end
   end

   // Parity register, cleared by the line reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign par_bit = par_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data (via serializer), optional parity, stop.
module uart_tx_ctrl
   import uart_tx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int DONE_TIMEOUT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  ser_data,
   input  logic                  ser_done,
   output logic                  ser_en,
   output logic [DATA_WIDTH-1:0] ser_p_data,
   output logic                  TX_OUT,
   output logic                  busy,
   output logic                  frame_err
);

   // DATA-state cycle counter: counts 0 .. DATA_WIDTH+DONE_TIMEOUT-1.
   localparam int CNT_W = $clog2(DATA_WIDTH + DONE_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH + DONE_TIMEOUT - 1);

   state_t                state_d, state_q;
   logic [DATA_WIDTH-1:0] data_d, data_q;
   logic                  par_en_d, par_en_q;
   logic [CNT_W-1:0]      cnt_d, cnt_q;
   logic                  frame_err_d, frame_err_q;
   logic                  accept;
   logic                  par_bit;

   // A request is taken only when the line is idle or on the final stop cycle.
   assign accept = Data_Valid && ((state_q == IDLE) || (state_q == STOP));

   // Next-state, byte/config capture and DATA timeout supervision.
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      par_en_d    = par_en_q;
      cnt_d       = cnt_q;
      frame_err_d = 1'b0;
      if (accept) begin
         data_d   = P_DATA;
         par_en_d = PAR_EN;
      end
      case (state_q)
         IDLE: begin
            if (accept) state_d = START;
         end
         START: begin
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA: begin
            if (ser_done) begin
               state_d = par_en_q ? PARITY : STOP;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = STOP;
               frame_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PARITY: begin
            state_d = STOP;
         end
         STOP: begin
            state_d = accept ? START : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer registers; a mid-frame reset aborts the frame at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         par_en_q    <= 1'b0;
         cnt_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         par_en_q    <= par_en_d;
         cnt_q       <= cnt_d;
         frame_err_q <= frame_err_d;
      end
   end

   uart_tx_ctrl_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity_calc (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .data    (P_DATA),
      .par_typ (PAR_TYP),
      .par_bit (par_bit)
   );

   // Line, busy and serializer-enable decode from the current state.
   always_comb begin
      TX_OUT = IDLE_BIT;
      busy   = 1'b0;
      ser_en = 1'b0;
      case (state_q)
         START: begin
            TX_OUT = START_BIT;
            busy   = 1'b1;
            ser_en = 1'b1;
         end
         DATA: begin
            TX_OUT = ser_data;
            busy   = 1'b1;
            ser_en = 1'b1;
         end
         PARITY: begin
            TX_OUT = par_bit;
            busy   = 1'b1;
         end
         STOP: begin
            TX_OUT = STOP_BIT;
            busy   = 1'b1;
         end
         default: begin
            TX_OUT = IDLE_BIT;
         end
      endcase
   end

   // Serializer sees the live input while it may load, else the frame's byte.
   assign ser_p_data = ((state_q == IDLE) || (state_q == STOP)) ? P_DATA : data_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a behavioural serializer and line model.
module tb_uart_tx_ctrl;

   localparam int DW   = 8;
   localparam int NONE = -10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] P_DATA = '0;
   logic          Data_Valid = 1'b0;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic          ser_data;
   logic          ser_done;
   logic          ser_en;
   logic [DW-1:0] ser_p_data;
   logic          TX_OUT;
   logic          busy;
   logic          frame_err;

   int   tests = 0;
   int   fails = 0;
   logic no_done = 1'b0;
   logic exp_q[$];

   always #5 clk = ~clk;

   uart_tx_ctrl #(.DATA_WIDTH(DW), .DONE_TIMEOUT(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .ser_data   (ser_data),
      .ser_done   (ser_done),
      .ser_en     (ser_en),
      .ser_p_data (ser_p_data),
      .TX_OUT     (TX_OUT),
      .busy       (busy),
      .frame_err  (frame_err)
   );

   // Serializer model: loads while disabled, emits one bit per enabled cycle.
   logic [DW-1:0] s_reg;
   logic          s_out;
   logic [4:0]    s_cnt;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_reg <= '0;
         s_out <= 1'b0;
         s_cnt <= '0;
      end else if (!ser_en) begin
         s_reg <= ser_p_data;
         s_cnt <= '0;
      end else begin
         s_out <= s_reg[0];
         s_reg <= s_reg >> 1;
         s_cnt <= s_cnt + 5'd1;
      end
   end
   assign ser_data = s_out;
   assign ser_done = !no_done && ser_en && (s_cnt == 5'(DW));

   task automatic chk(input string tag, input logic act, input logic exp);
      tests++;
      assert (act === exp) else begin
         fails++;
         $error("FAIL %s: got %0b expected %0b", tag, act, exp);
      end
   endtask

   // Expected line bits for one frame: start, LSB-first data, optional parity, stop.
   function automatic void push_frame(input logic [DW-1:0] b, input logic pen, input logic pty);
      int ones = 0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) begin
         exp_q.push_back(b[i]);
         ones += int'(b[i]);
      end
      if (pen) exp_q.push_back(logic'(ones % 2) ^ pty);
      exp_q.push_back(1'b1);
   endfunction

   task automatic send(input logic [DW-1:0] b, input logic pen, input logic pty);
      P_DATA = b; PAR_EN = pen; PAR_TYP = pty; Data_Valid = 1'b1;
      @(negedge clk);
      Data_Valid = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " idle tx"}, TX_OUT, 1'b1);
      chk({tag, " idle busy"}, busy, 1'b0);
      chk({tag, " idle err"}, frame_err, 1'b0);
   endtask

   // Walk the expected queue one line cycle at a time, then expect idle.
   task automatic run_expected(input string tag, input bit scramble, input int err_at,
                               input int drop_at, input int inj_at);
      int n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         if (scramble) begin
            P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
         end
         if (i == drop_at) Data_Valid = 1'b0;
         if (i == inj_at) begin
            Data_Valid = 1'b1; P_DATA = 8'hFF;
         end else if (i == inj_at + 1) begin
            Data_Valid = 1'b0;
         end
         chk($sformatf("%s tx[%0d]", tag, i), TX_OUT, exp_q[i]);
         chk($sformatf("%s busy[%0d]", tag, i), busy, 1'b1);
         chk($sformatf("%s err[%0d]", tag, i), frame_err, (i == err_at));
         @(negedge clk);
      end
      exp_q.delete();
      chk_idle(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] b;
      logic          pen, pty;

      repeat (2) @(negedge clk);
      chk("reset tx", TX_OUT, 1'b1);
      chk("reset busy", busy, 1'b0);
      chk("reset ser_en", ser_en, 1'b0);
      chk("reset err", frame_err, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk_idle("post reset");

      push_frame(8'hA5, 1'b0, 1'b0); send(8'hA5, 1'b0, 1'b0);
      run_expected("a5_nopar", 1'b0, NONE, NONE, NONE);
      push_frame(8'hA5, 1'b1, 1'b0); send(8'hA5, 1'b1, 1'b0);
      run_expected("a5_even", 1'b0, NONE, NONE, NONE);
      push_frame(8'h01, 1'b1, 1'b1); send(8'h01, 1'b1, 1'b1);
      run_expected("01_odd", 1'b0, NONE, NONE, NONE);
      push_frame(8'h03, 1'b1, 1'b1); send(8'h03, 1'b1, 1'b1);
      run_expected("03_odd", 1'b0, NONE, NONE, NONE);

      for (int k = 0; k < 8; k++) begin
         b = DW'($urandom); pen = 1'($urandom); pty = 1'($urandom);
         push_frame(b, pen, pty); send(b, pen, pty);
         run_expected($sformatf("rand%0d", k), 1'b1, NONE, NONE, NONE);
      end

      // Back-to-back with the request held: second start follows first stop.
      push_frame(8'h55, 1'b0, 1'b0); push_frame(8'h0F, 1'b0, 1'b0);
      P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      @(negedge clk);
      P_DATA = 8'h0F;
      run_expected("b2b", 1'b0, NONE, 11, NONE);

      // Request during DATA is ignored; 0xFF must never appear.
      push_frame(8'h00, 1'b0, 1'b0); send(8'h00, 1'b0, 1'b0);
      run_expected("ignore", 1'b0, NONE, NONE, 3);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_idle($sformatf("ignore tail%0d", k));
      end

      // Reset in the 4th DATA cycle aborts immediately.
      push_frame(8'hC3, 1'b0, 1'b0); send(8'hC3, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("abort tx[%0d]", i), TX_OUT, exp_q[i]);
         if (i < 4) @(negedge clk);
      end
      exp_q.delete();
      rst = 1'b0;
      #1;
      chk("abort tx", TX_OUT, 1'b1);
      chk("abort busy", busy, 1'b0);
      chk("abort ser_en", ser_en, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      push_frame(8'h3C, 1'b1, 1'b0); send(8'h3C, 1'b1, 1'b0);
      run_expected("after_abort", 1'b0, NONE, NONE, NONE);

      // Missing ser_done: 10 DATA cycles, error pulse with stop, parity skipped.
      no_done = 1'b1;
      b = DW'($urandom);
      exp_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) exp_q.push_back(b[i]);
      exp_q.push_back(1'b0); exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      send(b, 1'b1, 1'b0);
      run_expected("timeout", 1'b0, DW + 3, NONE, NONE);
      no_done = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
